// File: rtl/multiexp_window_sched.sv
// Windowed double-and-add scheduler: buffers NUM_IN (point, scalar) pairs, then
// streams ADD/DBL/END commands MSB window first, skipping zero digits and leading doublings.
module multiexp_window_sched #(
  parameter int PNT_BITS = 768,
  parameter int SCL_BITS = 256,
  parameter int NUM_IN   = 4,
  parameter int WIN_BITS = 4,
  parameter int CTL_BITS = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_pnt_scl_val,
  input  logic                         i_pnt_scl_sop,
  input  logic                         i_pnt_scl_eop,
  input  logic [PNT_BITS+SCL_BITS-1:0] i_pnt_scl_dat,
  input  logic [CTL_BITS-1:0]          i_pnt_scl_ctl,
  output logic                         o_pnt_scl_rdy,
  output logic                         o_cmd_val,
  output logic                         o_cmd_sop,
  output logic                         o_cmd_eop,
  output logic [PNT_BITS+WIN_BITS-1:0] o_cmd_dat,
  output logic [CTL_BITS-1:0]          o_cmd_ctl,
  input  logic                         i_cmd_rdy,
  output logic                         o_busy,
  output logic [1:0]                   o_state
);

  localparam int NUM_WIN = (SCL_BITS + WIN_BITS - 1) / WIN_BITS;
  localparam int SCL_PAD = NUM_WIN * WIN_BITS;
  localparam int IDX_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int DBL_W   = (WIN_BITS > 1) ? $clog2(WIN_BITS) : 1;

  localparam logic [1:0] OP_DBL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_END = 2'd2;

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_SCAN = 2'd1, S_DBL = 2'd2, S_END = 2'd3} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [WIN_W-1:0]            win_q, win_d;
  logic [DBL_W-1:0]            dbl_cnt_q, dbl_cnt_d;
  logic                        acc_nz_q, acc_nz_d;
  logic                        first_q, first_d;
  logic                        busy_q, busy_d;
  logic                        val_q, val_d, sop_q, sop_d, eop_q, eop_d;
  logic [PNT_BITS+WIN_BITS-1:0] dat_q, dat_d;
  logic [CTL_BITS-1:0]         ctl_q, ctl_d;

  logic [PNT_BITS-1:0] pnt_q [NUM_IN];
  logic [SCL_PAD-1:0]  scl_q [NUM_IN];
  logic [WIN_BITS-1:0] digit;
  logic                out_free;
  logic                load_fire;
  logic                unused_in;

  // Framing on the input side is ignored; the pair count alone closes a batch.
  assign unused_in = ^{i_pnt_scl_sop, i_pnt_scl_eop, i_pnt_scl_ctl};

  assign load_fire = (state_q == S_LOAD) && i_pnt_scl_val;
  assign out_free  = !val_q || i_cmd_rdy;
  assign digit     = scl_q[idx_q][win_q*WIN_BITS +: WIN_BITS];

  always_ff @(posedge i_clk) begin
    if (load_fire) begin
      pnt_q[load_cnt_q] <= i_pnt_scl_dat[PNT_BITS+SCL_BITS-1:SCL_BITS];
      scl_q[load_cnt_q] <= SCL_PAD'(i_pnt_scl_dat[SCL_BITS-1:0]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_LOAD;
      load_cnt_q <= '0;
      idx_q      <= '0;
      win_q      <= '0;
      dbl_cnt_q  <= '0;
      acc_nz_q   <= 1'b0;
      first_q    <= 1'b0;
      busy_q     <= 1'b0;
      val_q      <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      dat_q      <= '0;
      ctl_q      <= '0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      dbl_cnt_q  <= dbl_cnt_d;
      acc_nz_q   <= acc_nz_d;
      first_q    <= first_d;
      busy_q     <= busy_d;
      val_q      <= val_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      dat_q      <= dat_d;
      ctl_q      <= ctl_d;
    end
  end

  // Handshake: a command transfers on a cycle where o_cmd_val && i_cmd_rdy;
  // dat/ctl/sop/eop hold while val is high and rdy is low. A pair transfers
  // on i_pnt_scl_val && o_pnt_scl_rdy, and rdy is high only in LOAD.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    idx_d      = idx_q;
    win_d      = win_q;
    dbl_cnt_d  = dbl_cnt_q;
    acc_nz_d   = acc_nz_q;
    first_d    = first_q;
    busy_d     = busy_q;
    val_d      = val_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    dat_d      = dat_q;
    ctl_d      = ctl_q;
    if (val_q && i_cmd_rdy) begin
      val_d = 1'b0;
      sop_d = 1'b0;
      eop_d = 1'b0;
    end
    case (state_q)
      S_LOAD: begin
        if (i_pnt_scl_val) begin
          busy_d = 1'b1;
          if (load_cnt_q == IDX_W'(NUM_IN - 1)) begin
            load_cnt_d = '0;
            state_d    = S_SCAN;
            win_d      = WIN_W'(NUM_WIN - 1);
            idx_d      = '0;
            acc_nz_d   = 1'b0;
            first_d    = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q + IDX_W'(1);
          end
        end
      end
      S_SCAN: begin
        if (out_free) begin
          if (digit != '0) begin
            val_d    = 1'b1;
            sop_d    = first_q;
            eop_d    = 1'b0;
            first_d  = 1'b0;
            dat_d    = {pnt_q[idx_q], digit};
            ctl_d    = CTL_BITS'({idx_q, OP_ADD});
            acc_nz_d = 1'b1;
          end
          // Doublings only start once the accumulator holds a non-infinite point.
          if (idx_q == IDX_W'(NUM_IN - 1)) begin
            if (win_q == '0) begin
              state_d = S_END;
            end else begin
              win_d = win_q - WIN_W'(1);
              idx_d = '0;
              if (acc_nz_d) begin
                state_d   = S_DBL;
                dbl_cnt_d = '0;
              end
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DBL: begin
        if (out_free) begin
          val_d   = 1'b1;
          sop_d   = first_q;
          eop_d   = 1'b0;
          first_d = 1'b0;
          dat_d   = '0;
          ctl_d   = CTL_BITS'(OP_DBL);
          if (dbl_cnt_q == DBL_W'(WIN_BITS - 1)) state_d = S_SCAN;
          else dbl_cnt_d = dbl_cnt_q + DBL_W'(1);
        end
      end
      S_END: begin
        if (val_q && eop_q) begin
          if (i_cmd_rdy) begin
            busy_d  = 1'b0;
            state_d = S_LOAD;
          end
        end else if (out_free) begin
          val_d   = 1'b1;
          sop_d   = first_q;
          eop_d   = 1'b1;
          first_d = 1'b0;
          dat_d   = '0;
          ctl_d   = CTL_BITS'(OP_END);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign o_pnt_scl_rdy = (state_q == S_LOAD);
  assign o_cmd_val     = val_q;
  assign o_cmd_sop     = sop_q;
  assign o_cmd_eop     = eop_q;
  assign o_cmd_dat     = dat_q;
  assign o_cmd_ctl     = ctl_q;
  assign o_busy        = busy_q;
  assign o_state       = state_q;

endmodule
